// File: rtl/cmp_simd_pipe_if.sv
// Operand/result bundle for cmp_simd_pipe: the source drives the master side, the comparator takes the slave side.
interface cmp_simd_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    logic                     en;
    logic                     valid_in;
    logic [2:0]               op;
    logic                     sgn;
    logic [LANES*WIDTH-1:0]   a;
    logic [LANES*WIDTH-1:0]   b;
    logic [LANES-1:0]         y;
    logic                     all;
    logic                     any;
    logic                     valid_out;

    modport master (
        output en, valid_in, op, sgn, a, b,
        input  y, all, any, valid_out
    );

    modport slave (
        input  en, valid_in, op, sgn, a, b,
        output y, all, any, valid_out
    );
endinterface

// File: rtl/cmp_simd_pipe.sv
// Pipelined SIMD lane comparator with all/any reductions and output gating.
// Optional feature macro: CMP_SIGNED_EN (two's-complement lt/le/gt/ge when sgn = 1).
module cmp_simd_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 1,
    parameter int STAGES = 1
) (
    input  logic           clock,
    input  logic           reset,
    cmp_simd_pipe_if.slave bus
);

    // Each lane is widened by one bit: a zero for unsigned, the sign bit for signed.
    // A single signed compare of the widened values then covers both modes.
    function automatic logic lane_cmp(input logic [2:0] op_sel, input logic signed_sel,
                                      input logic [WIDTH-1:0] la, input logic [WIDTH-1:0] lb);
        logic signed [WIDTH:0] xa;
        logic signed [WIDTH:0] xb;
        xa = $signed({signed_sel & la[WIDTH-1], la});
        xb = $signed({signed_sel & lb[WIDTH-1], lb});
        case (op_sel)
            3'd0:    lane_cmp = (xa == xb);
            3'd1:    lane_cmp = (xa != xb);
            3'd2:    lane_cmp = (xa <  xb);
            3'd3:    lane_cmp = (xa <= xb);
            3'd4:    lane_cmp = (xa >  xb);
            3'd5:    lane_cmp = (xa >= xb);
            default: lane_cmp = 1'b0;
        endcase
    endfunction

    logic             signed_sel;
    logic [LANES-1:0] y_c;
    logic             all_c;
    logic             any_c;

`ifdef CMP_SIGNED_EN
    assign signed_sel = bus.sgn;
`else
    logic unused_sgn;
    assign unused_sgn = bus.sgn;
    assign signed_sel = 1'b0;
`endif

    always_comb begin
        y_c = '0;
        for (int i = 0; i < LANES; i++) begin
            y_c[i] = lane_cmp(bus.op, signed_sel, bus.a[i*WIDTH +: WIDTH], bus.b[i*WIDTH +: WIDTH]);
        end
        all_c = &y_c;
        any_c = |y_c;
    end

    logic [LANES-1:0] y_p   [STAGES];
    logic             all_p [STAGES];
    logic             any_p [STAGES];
    logic             vld_p [STAGES];

    // Stage 0 captures the compare; later stages are a plain shift chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_p[s] <= 1'b0;
                y_p[s]   <= '0;
                all_p[s] <= 1'b0;
                any_p[s] <= 1'b0;
            end
        end else if (bus.en) begin
            vld_p[0] <= bus.valid_in;
            y_p[0]   <= y_c;
            all_p[0] <= all_c;
            any_p[0] <= any_c;
            for (int s = 1; s < STAGES; s++) begin
                vld_p[s] <= vld_p[s-1];
                y_p[s]   <= y_p[s-1];
                all_p[s] <= all_p[s-1];
                any_p[s] <= any_p[s-1];
            end
        end
    end

    // Bubbles leave stale compare data in the chain; mask it at the output.
    assign bus.valid_out = vld_p[STAGES-1];
    assign bus.y         = vld_p[STAGES-1] ? y_p[STAGES-1] : '0;
    assign bus.all       = vld_p[STAGES-1] & all_p[STAGES-1];
    assign bus.any       = vld_p[STAGES-1] & any_p[STAGES-1];

endmodule
